seg7_scan_driver: RTL and testbench



---
 rtl/seg7_scan_driver.sv | 84 ++++++++
 tb/tb_seg7_scan_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: latches CPU-written word and scans it as hex onto an 8-digit two-bank 7-seg display
//   clk, reset (sync, active-high), wr_en/wr_data (write latch), disp_en (0 blanks outputs)
//   seg (left bank, bits [31:16]), seg1 (right bank, bits [15:0]), an (two-hot anodes),
//   frame_done (one-cycle pulse after each full 4-position scan)
//   Optional macro SEG7_LEAD_ZERO_BLANK_EN blanks leading zero digits per bank.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        disp_en,
    output logic [7:0]  seg,
    output logic [7:0]  seg1,
    output logic [7:0]  an,
    output logic        frame_done
);
    logic [31:0]      disp_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             tc;
    logic [3:0]       nib_l, nib_r, onehot;
    logic             blank_l, blank_r;

    function automatic logic [6:0] hex(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

`ifdef SEG7_LEAD_ZERO_BLANK_EN
    // Position of the highest non-zero nibble; position 0 is always shown
    function automatic logic [1:0] lead(input logic [15:0] b);
        return b[15:12] != 0 ? 2'd3 : b[11:8] != 0 ? 2'd2 : b[7:4] != 0 ? 2'd1 : 2'd0;
    endfunction
    assign blank_l = idx > lead(disp_q[31:16]);
    assign blank_r = idx > lead(disp_q[15:0]);
`else
    assign blank_l = 1'b0;
    assign blank_r = 1'b0;
`endif

    assign tc     = cnt == CNT_W'(SCAN_DIV - 1);
    assign nib_r  = disp_q[{idx, 2'b00} +: 4];
    assign nib_l  = disp_q[{1'b1, idx, 2'b00} +: 4];
    assign onehot = 4'b0001 << idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q     <= '0;
            cnt        <= '0;
            idx        <= '0;
            seg        <= '0;
            seg1       <= '0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= tc ? '0 : cnt + 1'b1;
            idx        <= tc ? idx + 2'd1 : idx;
            disp_q     <= wr_en ? wr_data : disp_q;
            frame_done <= tc && idx == 2'd3;
            an         <= disp_en ? {onehot, onehot} : 8'h00;
            seg        <= disp_en && !blank_l ? {1'b0, hex(nib_l)} : 8'h00;
            seg1       <= disp_en && !blank_r ? {1'b0, hex(nib_r)} : 8'h00;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench for seg7_scan_driver with SCAN_DIV=4
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        disp_en = 1'b1;
    logic [7:0]  seg, seg1, an;
    logic        frame_done;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        logic [7:0] seg1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    seg7_scan_driver #(.SCAN_DIV(4), .CNT_W(20)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .disp_en(disp_en),
        .seg(seg), .seg1(seg1), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // cyc = edges since reset release, so prescaler = cyc % 4
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc = reset ? 0 : cyc + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Anodes shown after edge c reflect the idx held before that edge
    function automatic logic [7:0] exp_an(input int c);
        logic [3:0] o;
        o = 4'b0001 << (((c - 1) / 4) % 4);
        return {o, o};
    endfunction

    task automatic wait_an(input logic [7:0] t);
        int n = 0;
        while (an !== t && n < 20) begin
            step(1);
            n++;
        end
        check("wait_an", {24'h0, an}, {24'h0, t});
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] s, input logic [7:0] s1);
        exp_t e;
        e.an = a;
        e.seg = s;
        e.seg1 = s1;
        q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL %s got=empty want=entry", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            wait_an(e.an);
            check({tag, "_seg"}, {24'h0, seg}, {24'h0, e.seg});
            check({tag, "_seg1"}, {24'h0, seg1}, {24'h0, e.seg1});
        end
    endtask

    task automatic write(input logic [31:0] d);
        wr_en = 1'b1;
        wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    initial begin
        // Reset with a write attempt that must be ignored
        wr_en = 1'b1;
        wr_data = 32'hFFFF_FFFF;
        step(2);
        wr_en = 1'b0;
        check("rst_an", {24'h0, an}, 32'h0);
        check("rst_seg", {24'h0, seg}, 32'h0);
        check("rst_seg1", {24'h0, seg1}, 32'h0);
        check("rst_fd", {31'h0, frame_done}, 32'h0);
        reset = 1'b0;
        step(1);
        check("first_an", {24'h0, an}, 32'h11);
        check("first_seg", {24'h0, seg}, 32'h3F);
        check("first_seg1", {24'h0, seg1}, 32'h3F);
        // Scan rate and frame pulse
        for (int i = 0; i < 39; i++) begin
            step(1);
            check("scan_an", {24'h0, an}, {24'h0, exp_an(cyc)});
            check("frame_done", {31'h0, frame_done}, {31'h0, cyc % 16 == 0});
        end
        // Back-to-back writes: last wins, then full scan of 0x1234_ABCD
        push(8'h11, 8'h66, 8'h5E);
        push(8'h22, 8'h4F, 8'h39);
        push(8'h44, 8'h5B, 8'h7C);
        push(8'h88, 8'h06, 8'h77);
        write(32'h1111_1111);
        write(32'h1234_ABCD);
        step(1);
        for (int k = 0; k < 4; k++) pop_check("pat");
        // Write coinciding with prescaler terminal count
        write(32'h0);
        step(2);
        while (cyc % 4 != 3) step(1);
        check("pre_tc_seg", {24'h0, seg}, 32'h3F);
        write(32'hFFFF_FFFF);
        step(1);
        check("tc_an", {24'h0, an}, {24'h0, exp_an(cyc)});
        check("tc_seg", {24'h0, seg}, 32'h71);
        check("tc_seg1", {24'h0, seg1}, 32'h71);
        // Display disable at idx 2 for 10 cycles
        wait_an(8'h44);
        disp_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("off_an", {24'h0, an}, 32'h0);
            check("off_seg", {16'h0, seg, seg1}, 32'h0);
        end
        disp_en = 1'b1;
        step(1);
        check("on_an", {24'h0, an}, {24'h0, exp_an(cyc)});
        check("on_seg", {16'h0, seg, seg1}, 32'h7171);
        // Reset mid-scan at idx 3
        write(32'h8888_8888);
        step(1);
        wait_an(8'h88);
        check("pre_rst_seg", {16'h0, seg, seg1}, 32'h7F7F);
        reset = 1'b1;
        step(1);
        check("mid_rst_out", {seg, seg1, an, 7'h0, frame_done}, 32'h0);
        reset = 1'b0;
        step(1);
        check("post_rst_an", {24'h0, an}, 32'h11);
        check("post_rst_seg", {16'h0, seg, seg1}, 32'h3F3F);
        // Leading-zero handling for 0x0000_00A5
`ifdef SEG7_LEAD_ZERO_BLANK_EN
        push(8'h11, 8'h3F, 8'h6D);
        push(8'h22, 8'h00, 8'h77);
        push(8'h44, 8'h00, 8'h00);
        push(8'h88, 8'h00, 8'h00);
`else
        push(8'h11, 8'h3F, 8'h6D);
        push(8'h22, 8'h3F, 8'h77);
        push(8'h44, 8'h3F, 8'h3F);
        push(8'h88, 8'h3F, 8'h3F);
`endif
        write(32'h0000_00A5);
        step(1);
        for (int k = 0; k < 4; k++) pop_check("lz");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
